// File: rtl/icmp_vlg_tx_echo.sv
// ICMP echo responder, transmit side: buffers an echo request and replays it as an echo reply
// with the header checksum patched for the 8 -> 0 type change.
module icmp_vlg_tx_echo #(
   parameter int MAX_PLD = 1472,
   parameter int PLD_AW  = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_dat,
   input  logic        in_val,
   input  logic        in_sof,
   input  logic        in_eof,
   input  logic        in_err,
   input  logic [31:0] in_src_ip,
   output logic [7:0]  out_dat,
   output logic        out_val,
   output logic        out_sof,
   output logic        out_eof,
   input  logic        out_rdy,
   output logic [15:0] out_len,
   output logic [31:0] out_dst_ip,
   output logic        busy
);

   // state  | meaning
   // IDLE   | waiting for in_sof
   // RX_HDR | capturing ICMP header bytes 1..7
   // RX_PLD | writing echo data into the buffer
   // CALC   | patch checksum, latch reply length and destination
   // TX_HDR | emitting the 8 reply header bytes
   // TX_PLD | emitting buffered data
   // DROP   | discarding the rest of an unwanted datagram
   typedef enum logic [2:0] {
      S_IDLE, S_RX_HDR, S_RX_PLD, S_CALC, S_TX_HDR, S_TX_PLD, S_DROP
   } state_t;

   localparam int CW = PLD_AW + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PLD);
   localparam logic [CW-1:0] ONE     = CW'(1);

   state_t        state_q, state_d;
   logic [2:0]    hdr_idx_q, hdr_idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] pld_len_q, pld_len_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [15:0]   cks_q, cks_d;
   logic [15:0]   id_q, id_d;
   logic [15:0]   seq_q, seq_d;
   logic [31:0]   src_ip_q, src_ip_d;
   logic [7:0]    out_dat_q, out_dat_d;
   logic          out_val_q, out_val_d;
   logic          out_sof_q, out_sof_d;
   logic          out_eof_q, out_eof_d;
   logic [15:0]   out_len_q, out_len_d;
   logic [31:0]   out_dst_ip_q, out_dst_ip_d;
   logic [7:0]    rd_dat_q;
   logic          mem_we;
   logic          tx_acc, tx_ld;
   logic [16:0]   cks_sum;
   logic [15:0]   cks_rep;
   logic [7:0]    pld_mem [2**PLD_AW];

   always_comb begin
      state_d      = state_q;
      hdr_idx_d    = hdr_idx_q;
      cnt_d        = cnt_q;
      pld_len_d    = pld_len_q;
      rd_ptr_d     = rd_ptr_q;
      cks_d        = cks_q;
      id_d         = id_q;
      seq_d        = seq_q;
      src_ip_d     = src_ip_q;
      out_dat_d    = out_dat_q;
      out_val_d    = out_val_q;
      out_sof_d    = out_sof_q;
      out_eof_d    = out_eof_q;
      out_len_d    = out_len_q;
      out_dst_ip_d = out_dst_ip_q;
      mem_we       = 1'b0;
      tx_acc       = out_val_q & out_rdy;
      tx_ld        = ~out_val_q | out_rdy;
      // type 8 -> 0 lowers the first header word by 0x0800, so the complement sum rises by it
      cks_sum      = {1'b0, cks_q} + 17'h0800;
      cks_rep      = cks_sum[15:0] + {15'd0, cks_sum[16]};

      case (state_q)
         S_IDLE, S_DROP: begin
            if (in_val && in_sof) begin
               src_ip_d  = in_src_ip;
               hdr_idx_d = 3'd1;
               if (in_eof)                state_d = S_IDLE;
               else if (in_dat != 8'h08)  state_d = S_DROP;
               else                       state_d = S_RX_HDR;
            end else if (state_q == S_DROP && in_val && in_eof) begin
               state_d = S_IDLE;
            end
         end
         S_RX_HDR: begin
            if (in_val) begin
               hdr_idx_d = hdr_idx_q + 3'd1;
               case (hdr_idx_q)
                  3'd2:    cks_d[15:8] = in_dat;
                  3'd3:    cks_d[7:0]  = in_dat;
                  3'd4:    id_d[15:8]  = in_dat;
                  3'd5:    id_d[7:0]   = in_dat;
                  3'd6:    seq_d[15:8] = in_dat;
                  3'd7:    seq_d[7:0]  = in_dat;
                  default: ;
               endcase
               if (in_eof) begin
                  if (hdr_idx_q == 3'd7 && !in_err) begin
                     state_d   = S_CALC;
                     pld_len_d = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else if (hdr_idx_q == 3'd1 && in_dat != 8'h00) begin
                  state_d = S_DROP;
               end else if (hdr_idx_q == 3'd7) begin
                  state_d = S_RX_PLD;
                  cnt_d   = '0;
               end
            end
         end
         S_RX_PLD: begin
            if (in_val) begin
               if (cnt_q == MAX_CNT) begin
                  state_d = in_eof ? S_IDLE : S_DROP;
               end else begin
                  mem_we = 1'b1;
                  cnt_d  = cnt_q + ONE;
                  if (in_eof) begin
                     if (in_err) begin
                        state_d = S_IDLE;
                     end else begin
                        state_d   = S_CALC;
                        pld_len_d = cnt_q + ONE;
                     end
                  end
               end
            end
         end
         S_CALC: begin
            cks_d        = cks_rep;
            out_len_d    = 16'(pld_len_q) + 16'd8;
            out_dst_ip_d = src_ip_q;
            hdr_idx_d    = 3'd0;
            rd_ptr_d     = '0;
            state_d      = S_TX_HDR;
         end
         S_TX_HDR, S_TX_PLD: begin
            if (tx_acc && out_eof_q) begin
               state_d      = S_IDLE;
               out_dat_d    = 8'h00;
               out_val_d    = 1'b0;
               out_sof_d    = 1'b0;
               out_eof_d    = 1'b0;
               out_len_d    = 16'h0000;
               out_dst_ip_d = 32'h0;
            end else if (tx_ld) begin
               out_val_d = 1'b1;
               out_sof_d = 1'b0;
               out_eof_d = 1'b0;
               if (state_q == S_TX_HDR) begin
                  case (hdr_idx_q)
                     3'd2:    out_dat_d = cks_q[15:8];
                     3'd3:    out_dat_d = cks_q[7:0];
                     3'd4:    out_dat_d = id_q[15:8];
                     3'd5:    out_dat_d = id_q[7:0];
                     3'd6:    out_dat_d = seq_q[15:8];
                     3'd7:    out_dat_d = seq_q[7:0];
                     default: out_dat_d = 8'h00;
                  endcase
                  out_sof_d = (hdr_idx_q == 3'd0);
                  hdr_idx_d = hdr_idx_q + 3'd1;
                  if (hdr_idx_q == 3'd7) begin
                     if (pld_len_q == '0) out_eof_d = 1'b1;
                     else                 state_d   = S_TX_PLD;
                  end
               end else begin
                  out_dat_d = rd_dat_q;
                  out_eof_d = (rd_ptr_q == pld_len_q - ONE);
                  rd_ptr_d  = rd_ptr_q + ONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         hdr_idx_q    <= '0;
         cnt_q        <= '0;
         pld_len_q    <= '0;
         rd_ptr_q     <= '0;
         cks_q        <= '0;
         id_q         <= '0;
         seq_q        <= '0;
         src_ip_q     <= '0;
         out_dat_q    <= '0;
         out_val_q    <= 1'b0;
         out_sof_q    <= 1'b0;
         out_eof_q    <= 1'b0;
         out_len_q    <= '0;
         out_dst_ip_q <= '0;
      end else begin
         state_q      <= state_d;
         hdr_idx_q    <= hdr_idx_d;
         cnt_q        <= cnt_d;
         pld_len_q    <= pld_len_d;
         rd_ptr_q     <= rd_ptr_d;
         cks_q        <= cks_d;
         id_q         <= id_d;
         seq_q        <= seq_d;
         src_ip_q     <= src_ip_d;
         out_dat_q    <= out_dat_d;
         out_val_q    <= out_val_d;
         out_sof_q    <= out_sof_d;
         out_eof_q    <= out_eof_d;
         out_len_q    <= out_len_d;
         out_dst_ip_q <= out_dst_ip_d;
      end
   end

   // read address follows rd_ptr_d so rd_dat_q always holds the byte at rd_ptr_q
   always_ff @(posedge clk) begin
      if (mem_we) pld_mem[cnt_q[PLD_AW-1:0]] <= in_dat;
      rd_dat_q <= pld_mem[rd_ptr_d[PLD_AW-1:0]];
   end

   assign out_dat    = out_dat_q;
   assign out_val    = out_val_q;
   assign out_sof    = out_sof_q;
   assign out_eof    = out_eof_q;
   assign out_len    = out_len_q;
   assign out_dst_ip = out_dst_ip_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_icmp_vlg_tx_echo.sv
// Bench for icmp_vlg_tx_echo: requests are driven byte-wise, expected reply bytes are queued
// at drive time and compared as the DUT hands them over.
module tb_icmp_vlg_tx_echo;

   localparam int MAX_PLD = 1472;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_dat;
   logic        in_val, in_sof, in_eof, in_err;
   logic [31:0] in_src_ip;
   logic [7:0]  out_dat;
   logic        out_val, out_sof, out_eof, out_rdy;
   logic [15:0] out_len;
   logic [31:0] out_dst_ip;
   logic        busy;

   always #5 clk = ~clk;

   icmp_vlg_tx_echo #(.MAX_PLD(MAX_PLD), .PLD_AW(11)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_dat(in_dat), .in_val(in_val), .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err),
      .in_src_ip(in_src_ip),
      .out_dat(out_dat), .out_val(out_val), .out_sof(out_sof), .out_eof(out_eof),
      .out_rdy(out_rdy), .out_len(out_len), .out_dst_ip(out_dst_ip), .busy(busy)
   );

   typedef struct packed {
      logic [7:0]  dat;
      logic        sof;
      logic        eof;
      logic [15:0] len;
      logic [31:0] ip;
   } exp_t;

   int          checks = 0;
   int          failures = 0;
   exp_t        exp_q[$];
   logic [7:0]  pld_q[$];

   // one's-complement add of 0x0800, written as plain integer arithmetic
   function automatic logic [15:0] exp_cks(input logic [15:0] c);
      int s;
      s = int'(c) + 32'h0800;
      if (s > 32'hFFFF) s = s - 32'hFFFF;
      return s[15:0];
   endfunction

   // monitor: byte acceptance happens at the next posedge when out_val & out_rdy here
   logic       in_frame = 1'b0;
   logic       stall_prev = 1'b0;
   logic [10:0] held;
   exp_t       e;
   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame   = 1'b0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if ({out_val, out_dat, out_sof, out_eof} !== held) begin
               failures++;
               $display("FAIL hold: got %h required %h", {out_val, out_dat, out_sof, out_eof}, held);
            end
         end
         if (in_frame) begin
            checks++;
            if (out_val !== 1'b1) begin
               failures++;
               $display("FAIL frame_gap: out_val=%b required 1", out_val);
            end
         end
         if (out_val && out_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_byte: got dat=%h sof=%b eof=%b required no output",
                        out_dat, out_sof, out_eof);
            end else begin
               e = exp_q.pop_front();
               if ({out_dat, out_sof, out_eof, out_len, out_dst_ip} !== e) begin
                  failures++;
                  $display("FAIL reply_byte: got dat=%h sof=%b eof=%b len=%0d ip=%h required dat=%h sof=%b eof=%b len=%0d ip=%h",
                           out_dat, out_sof, out_eof, out_len, out_dst_ip,
                           e.dat, e.sof, e.eof, e.len, e.ip);
               end
            end
            if (out_sof) in_frame = 1'b1;
            if (out_eof) in_frame = 1'b0;
         end
         stall_prev = out_val && !out_rdy;
         held       = {out_val, out_dat, out_sof, out_eof};
      end
   end

   task automatic send_req(input logic [7:0] typ, input logic [7:0] code, input logic [15:0] cks,
                           input logic [15:0] id, input logic [15:0] seq, input logic [31:0] src,
                           input logic err, input logic want);
      logic [7:0] hdr [8];
      logic [7:0] rep [8];
      logic [15:0] rc;
      exp_t x;
      int n;
      n = pld_q.size();
      rc = exp_cks(cks);
      hdr = '{typ, code, cks[15:8], cks[7:0], id[15:8], id[7:0], seq[15:8], seq[7:0]};
      rep = '{8'h00, 8'h00, rc[15:8], rc[7:0], id[15:8], id[7:0], seq[15:8], seq[7:0]};
      if (want) begin
         for (int i = 0; i < 8 + n; i++) begin
            if (i < 8) x.dat = rep[i];
            else       x.dat = pld_q[i-8];
            x.sof = (i == 0);
            x.eof = (i == 7 + n);
            x.len = 16'(8 + n);
            x.ip  = src;
            exp_q.push_back(x);
         end
      end
      in_src_ip = src;
      for (int i = 0; i < 8 + n; i++) begin
         if (i < 8) in_dat = hdr[i];
         else       in_dat = pld_q[i-8];
         in_val = 1'b1;
         in_sof = (i == 0);
         in_eof = (i == 7 + n);
         in_err = (i == 7 + n) && err;
         @(posedge clk); #1;
      end
      in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0; in_dat = 8'h00;
   endtask

   task automatic fill_pld(input int n);
      pld_q.delete();
      for (int i = 0; i < n; i++) pld_q.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic wait_drain(input string name, input int budget, input logic rand_rdy);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || busy) && k < budget) begin
         if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         k++;
      end
      out_rdy = 1'b1;
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_drain: pending=%0d busy=%b required pending=0 busy=0", name, exp_q.size(), busy);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out_val, out_sof, out_eof, out_dat, out_len, out_dst_ip, busy} !== 60'h0) begin
         failures++;
         $display("FAIL reset_outputs: val=%b sof=%b eof=%b dat=%h len=%h ip=%h busy=%b required all 0",
                  out_val, out_sof, out_eof, out_dat, out_len, out_dst_ip, busy);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || out_val !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: busy=%b out_val=%b required 0 0", busy, out_val);
      end
   endtask

   task automatic test_basic();
      pld_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_req(8'h08, 8'h00, 16'h1234, 16'h0001, 16'h0007, 32'h0A000005, 1'b0, 1'b1);
      checks++;
      if (out_val !== 1'b0) begin
         failures++;
         $display("FAIL latency_calc: out_val=%b required 0", out_val);
      end
      @(posedge clk); #1;
      checks++;
      if (out_val !== 1'b0) begin
         failures++;
         $display("FAIL latency_1: out_val=%b required 0", out_val);
      end
      @(posedge clk); #1;
      checks++;
      if (out_val !== 1'b1 || out_sof !== 1'b1) begin
         failures++;
         $display("FAIL latency_2: out_val=%b out_sof=%b required 1 1", out_val, out_sof);
      end
      wait_drain("basic", 100, 1'b0);
      checks++;
      if ({out_val, out_len, out_dst_ip} !== 49'h0) begin
         failures++;
         $display("FAIL basic_post_frame: val=%b len=%h ip=%h required 0", out_val, out_len, out_dst_ip);
      end
   endtask

   task automatic test_cks_wrap();
      logic [15:0] vals [3];
      vals = '{16'hF900, 16'hF800, 16'hF7FF};
      for (int i = 0; i < 3; i++) begin
         pld_q.delete();
         send_req(8'h08, 8'h00, vals[i], 16'hA5A0 + 16'(i), 16'h0100 + 16'(i), 32'hC0A80101, 1'b0, 1'b1);
         wait_drain("cks_wrap", 100, 1'b0);
      end
   endtask

   task automatic check_no_reply(input string name);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_busy: busy=%b required 0", name, busy);
      end
   endtask

   task automatic test_drop();
      fill_pld(4);
      send_req(8'h0D, 8'h00, 16'h1111, 16'h0002, 16'h0003, 32'h0A000006, 1'b0, 1'b0);
      check_no_reply("drop_type");
      send_req(8'h08, 8'h01, 16'h1111, 16'h0002, 16'h0003, 32'h0A000006, 1'b0, 1'b0);
      check_no_reply("drop_code");
      send_req(8'h08, 8'h00, 16'h1111, 16'h0002, 16'h0003, 32'h0A000006, 1'b1, 1'b0);
      check_no_reply("drop_err");
      for (int i = 0; i < 4; i++) begin
         in_dat = (i == 0) ? 8'h08 : 8'h00;
         in_val = 1'b1; in_sof = (i == 0); in_eof = (i == 3);
         @(posedge clk); #1;
      end
      in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
      check_no_reply("drop_runt");
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (out_val !== 1'b0) begin
         failures++;
         $display("FAIL drop_quiet: out_val=%b required 0", out_val);
      end
   endtask

   task automatic test_oversize();
      fill_pld(MAX_PLD + 1);
      send_req(8'h08, 8'h00, 16'h2222, 16'h0004, 16'h0005, 32'h0A000007, 1'b0, 1'b0);
      check_no_reply("oversize");
      pld_q.delete();
      send_req(8'h08, 8'h00, 16'h3333, 16'h0006, 16'h0007, 32'h0A000008, 1'b0, 1'b1);
      wait_drain("zero_data", 100, 1'b0);
      fill_pld(MAX_PLD);
      send_req(8'h08, 8'h00, 16'h4444, 16'h0008, 16'h0009, 32'h0A000009, 1'b0, 1'b1);
      wait_drain("max_data", 4000, 1'b0);
   endtask

   task automatic test_backpressure();
      fill_pld(64);
      send_req(8'h08, 8'h00, 16'h5555, 16'h000A, 16'h000B, 32'h0A00000A, 1'b0, 1'b1);
      wait_drain("backpressure", 2000, 1'b1);
   endtask

   task automatic test_reset_mid();
      int k;
      fill_pld(64);
      send_req(8'h08, 8'h00, 16'h6666, 16'h000C, 16'h000D, 32'h0A00000B, 1'b0, 1'b1);
      k = 0;
      while (exp_q.size() > 40 && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (busy !== 1'b1 || out_val !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_pre: busy=%b out_val=%b required 1 1", busy, out_val);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_val !== 1'b0 || busy !== 1'b0 || out_eof !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: out_val=%b busy=%b out_eof=%b required 0 0 0", out_val, busy, out_eof);
      end
      exp_q.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      pld_q = '{8'h01, 8'h02, 8'h03};
      send_req(8'h08, 8'h00, 16'h7777, 16'h000E, 16'h000F, 32'h0A00000C, 1'b0, 1'b1);
      wait_drain("after_reset", 100, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_dat = 8'h00; in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
      in_src_ip = 32'h0; out_rdy = 1'b1;
      #1;
      test_reset();
      test_basic();
      test_cks_wrap();
      test_drop();
      test_oversize();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
